// File: rtl/micro_sequencer_pkg.sv
// Shared sequencing-op encodings and field-width helpers for the micro_sequencer slice.
package micro_sequencer_pkg;

    localparam int SEQ_OP_W = 3;

    typedef enum logic [SEQ_OP_W-1:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_DISPATCH = 3'd1,
        SEQ_BRANCH   = 3'd2,
        SEQ_CALL     = 3'd3,
        SEQ_RET      = 3'd4
    } seq_op_e;

    localparam int DEFAULT_FETCH_ADDR = 0;

    // A single flag still needs a one-bit selector field in the microword.
    function automatic int csel_width(input int flags_w);
        return (flags_w > 1) ? $clog2(flags_w) : 1;
    endfunction

    function automatic int word_width(input int addr_w, input int sig_w, input int flags_w);
        return addr_w + sig_w + 1 + csel_width(flags_w) + SEQ_OP_W;
    endfunction

endpackage

// File: rtl/micro_sequencer_call_stack.sv
// LIFO of micro return addresses; push/pop are ignored when full/empty respectively.
module micro_call_stack #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_top
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [SP_W-1:0]   r_sp;
    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];

    assign o_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign o_empty = (r_sp == '0);

    always_comb begin
        o_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) o_top = r_mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entry storage carries no reset; only the pointer defines what is live.
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (r_sp == SP_W'(i)) r_mem[i] <= i_data;
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control sequencer: registered microword, opcode dispatch, flag branches, call/return.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int SIG_W       = 24,
    parameter int OPCODE_W    = 5,
    parameter int FLAGS_W     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = DEFAULT_FETCH_ADDR,
    parameter logic [(2**ADDR_W)*word_width(ADDR_W, SIG_W, FLAGS_W)-1:0] MICRO_IMAGE = '0,
    parameter logic [(2**OPCODE_W)*(ADDR_W+1)-1:0] DISPATCH_IMAGE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAGS_W-1:0]  flags,
    output logic [SIG_W-1:0]    signals,
    output logic [ADDR_W-1:0]   upc,
    output logic                illegal_op,
    output logic                stack_err
);

    localparam int CSEL_W  = csel_width(FLAGS_W);
    localparam int SEL_LSB = SEQ_OP_W;
    localparam int INV_BIT = SEL_LSB + CSEL_W;
    localparam int SIG_LSB = INV_BIT + 1;
    localparam int NXT_LSB = SIG_LSB + SIG_W;
    localparam int WORD_W  = NXT_LSB + ADDR_W;
    localparam int DENT_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);

    logic [WORD_W-1:0] r_word;
    logic [ADDR_W-1:0] r_upc;
    logic              r_illegal;
    logic              r_err;

    seq_op_e           w_op;
    logic [CSEL_W-1:0] w_sel;
    logic              w_inv;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [DENT_W-1:0] w_disp;
    logic              w_flag;
    logic [ADDR_W-1:0] w_chosen;
    logic              w_push;
    logic              w_pop;
    logic              w_illegal;
    logic              w_err;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;
    logic [WORD_W-1:0] w_store_word;

    assign w_op      = seq_op_e'(r_word[SEL_LSB-1:0]);
    assign w_sel     = r_word[INV_BIT-1:SEL_LSB];
    assign w_inv     = r_word[INV_BIT];
    assign w_next    = r_word[WORD_W-1:NXT_LSB];
    assign w_upc_inc = r_upc + ADDR_W'(1);
    assign w_disp    = DISPATCH_IMAGE[int'(opcode)*DENT_W +: DENT_W];

    always_comb begin
        w_flag = 1'b0;
        if (int'(w_sel) < FLAGS_W) w_flag = flags[w_sel];
    end

    always_comb begin
        w_chosen  = w_next;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_illegal = 1'b0;
        w_err     = 1'b0;
        case (w_op)
            SEQ_NEXT: w_chosen = w_next;
            SEQ_DISPATCH: begin
                if (w_disp[ADDR_W]) begin
                    w_chosen = w_disp[ADDR_W-1:0];
                end else begin
                    w_chosen  = FETCH;
                    w_illegal = 1'b1;
                end
            end
            SEQ_BRANCH: w_chosen = (w_flag ^ w_inv) ? w_next : w_upc_inc;
            // Overflowing call still jumps; only the return address is lost.
            SEQ_CALL: begin
                w_chosen = w_next;
                if (w_full) w_err = 1'b1;
                else        w_push = 1'b1;
            end
            SEQ_RET: begin
                if (w_empty) begin
                    w_chosen = FETCH;
                    w_err    = 1'b1;
                end else begin
                    w_chosen = w_top;
                    w_pop    = 1'b1;
                end
            end
            default: begin
                w_chosen = FETCH;
                w_err    = 1'b1;
            end
        endcase
    end

    assign w_store_word = MICRO_IMAGE[int'(w_chosen)*WORD_W +: WORD_W];

    micro_call_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push & ~stall),
        .i_pop   (w_pop & ~stall),
        .i_data  (w_upc_inc),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_top   (w_top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word    <= '0;
            r_upc     <= '0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
        end else if (stall) begin
            r_illegal <= 1'b0;
        end else begin
            r_word    <= w_store_word;
            r_upc     <= w_chosen;
            r_illegal <= w_illegal;
            if (w_err) r_err <= 1'b1;
        end
    end

    assign signals    = r_word[NXT_LSB-1:SIG_LSB];
    assign upc        = r_upc;
    assign illegal_op = r_illegal;
    assign stack_err  = r_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboarded bench for micro_sequencer driven by a small test microprogram defined here.
module tb_micro_sequencer;

    localparam int AW = 5;
    localparam int SW = 24;
    localparam int OW = 5;
    localparam int FW = 4;
    localparam int CW = 2;
    localparam int WW = AW + SW + 1 + CW + 3;

    function automatic logic [SW-1:0] sigv(input int a);
        return SW'(((a + 1) * 32'h000B3A5D) ^ 32'h005A5A5A);
    endfunction

    // Test microprogram: {next, signals, cond_inv, cond_sel, seq_op}
    function automatic logic [WW-1:0] uword(input int a);
        logic [2:0]    op;
        logic [CW-1:0] sel;
        logic          inv;
        logic [AW-1:0] nx;
        op = 3'd0; sel = '0; inv = 1'b0; nx = '0;
        case (a)
            0:  nx = 5'd1;
            1:  op = 3'd1;
            2:  nx = 5'd1;
            3:  begin op = 3'd2; sel = 2'd3; nx = 5'd1; end
            4:  begin op = 3'd3; nx = 5'd6; end
            5:  nx = 5'd1;
            6:  begin op = 3'd3; nx = 5'd8; end
            7:  op = 3'd4;
            8:  begin op = 3'd3; nx = 5'd17; end
            9:  op = 3'd4;
            10: begin op = 3'd2; sel = 2'd1; nx = 5'd20; end
            11: nx = 5'd1;
            12: begin op = 3'd2; sel = 2'd1; inv = 1'b1; nx = 5'd20; end
            13: nx = 5'd1;
            14: begin op = 3'd3; nx = 5'd25; end
            15: nx = 5'd1;
            16: begin op = 3'd2; sel = 2'd2; inv = 1'b1; nx = 5'd1; end
            17: begin op = 3'd3; nx = 5'd21; end
            18: op = 3'd4;
            20: nx = 5'd1;
            21: begin op = 3'd3; nx = 5'd23; end
            23: op = 3'd4;
            25: nx = 5'd26;
            26: op = 3'd4;
            27: op = 3'd4;
            28: op = 3'd6;
            29: op = 3'd5;
            30: op = 3'd7;
            31: begin op = 3'd2; sel = 2'd0; nx = 5'd1; end
            default: nx = 5'd0;
        endcase
        return {nx, sigv(a), inv, sel, op};
    endfunction

    function automatic logic [AW:0] dent(input int o);
        case (o)
            1:  return {1'b1, 5'd10};
            2:  return {1'b1, 5'd14};
            3:  return {1'b1, 5'd4};
            4:  return {1'b1, 5'd27};
            5:  return {1'b1, 5'd28};
            7:  return {1'b1, 5'd2};
            8:  return {1'b1, 5'd12};
            9:  return {1'b1, 5'd29};
            10: return {1'b1, 5'd30};
            11: return {1'b1, 5'd31};
            12: return {1'b1, 5'd3};
            13: return {1'b1, 5'd16};
            default: return '0;
        endcase
    endfunction

    function automatic logic [32*WW-1:0] build_micro();
        logic [32*WW-1:0] img;
        img = '0;
        for (int i = 0; i < 32; i++) img[i*WW +: WW] = uword(i);
        return img;
    endfunction

    function automatic logic [32*(AW+1)-1:0] build_disp();
        logic [32*(AW+1)-1:0] img;
        img = '0;
        for (int i = 0; i < 32; i++) img[i*(AW+1) +: (AW+1)] = dent(i);
        return img;
    endfunction

    localparam logic [32*WW-1:0]     MIMG = build_micro();
    localparam logic [32*(AW+1)-1:0] DIMG = build_disp();

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic [FW-1:0] flags = '0;
    logic [SW-1:0] signals;
    logic [AW-1:0] upc;
    logic          illegal_op;
    logic          stack_err;

    micro_sequencer #(
        .ADDR_W         (AW),
        .SIG_W          (SW),
        .OPCODE_W       (OW),
        .FLAGS_W        (FW),
        .STACK_DEPTH    (4),
        .FETCH_ADDR     (0),
        .MICRO_IMAGE    (MIMG),
        .DISPATCH_IMAGE (DIMG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .opcode     (opcode),
        .flags      (flags),
        .signals    (signals),
        .upc        (upc),
        .illegal_op (illegal_op),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] upc;
        logic [SW-1:0] sig;
        logic          ill;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc_n = 0;

    logic [WW-1:0] m_cur;
    logic [AW-1:0] m_upc;
    logic [AW-1:0] m_stk[$];
    logic          m_ill;
    logic          m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h want %0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic [OW-1:0] op,
                              input logic [FW-1:0] fl);
        logic [2:0]    sop;
        logic [CW-1:0] sel;
        logic          inv;
        logic [AW-1:0] nx;
        logic [AW-1:0] ch;
        logic [AW:0]   d;
        exp_t          e;
        if (r) begin
            m_cur = '0; m_upc = '0; m_stk.delete(); m_ill = 1'b0; m_err = 1'b0;
        end else if (s) begin
            m_ill = 1'b0;
        end else begin
            sop = m_cur[2:0];
            sel = m_cur[4:3];
            inv = m_cur[5];
            nx  = m_cur[WW-1 -: AW];
            m_ill = 1'b0;
            ch = '0;
            case (sop)
                3'd0: ch = nx;
                3'd1: begin
                    d = dent(int'(op));
                    if (d[AW]) ch = d[AW-1:0];
                    else begin ch = '0; m_ill = 1'b1; end
                end
                3'd2: ch = (fl[sel] ^ inv) ? nx : m_upc + 5'd1;
                3'd3: begin
                    if (m_stk.size() == 4) m_err = 1'b1;
                    else m_stk.push_back(m_upc + 5'd1);
                    ch = nx;
                end
                3'd4: begin
                    if (m_stk.size() == 0) begin ch = '0; m_err = 1'b1; end
                    else ch = m_stk.pop_back();
                end
                default: begin ch = '0; m_err = 1'b1; end
            endcase
            m_cur = uword(int'(ch));
            m_upc = ch;
        end
        e.upc = m_upc;
        e.sig = m_cur[WW-AW-1 -: SW];
        e.ill = m_ill;
        e.err = m_err;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic [OW-1:0] op, input logic [FW-1:0] fl);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; opcode = op; flags = fl;
        model_step(r, s, op, fl);
        @(posedge clk);
        #1;
        cyc_n++;
        e = sb_q.pop_front();
        check_val("upc", 32'(upc), 32'(e.upc));
        check_val("signals", 32'(signals), 32'(e.sig));
        check_val("illegal_op", 32'(illegal_op), 32'(e.ill));
        check_val("stack_err", 32'(stack_err), 32'(e.err));
    endtask

    task automatic go(input logic [OW-1:0] op, input logic [FW-1:0] fl, input int n);
        repeat (n) cyc(1'b0, 1'b0, op, fl);
    endtask

    task automatic rst_cycles(input int n);
        repeat (n) cyc(1'b1, 1'b0, '0, '0);
    endtask

    int nest_exp[10] = '{6, 8, 17, 21, 23, 18, 9, 7, 5, 1};
    int rsv_ops[3]   = '{5, 9, 10};
    int stall_ops[4] = '{7, 31, 1, 2};

    initial begin
        // Reset and release
        rst_cycles(3);
        check_val("rst_upc", 32'(upc), 0);
        check_val("rst_sig", 32'(signals), 0);
        go(5'd0, 4'd0, 1);
        check_val("rel_upc", 32'(upc), 0);
        check_val("rel_sig", 32'(signals), 32'(sigv(0)));
        go(5'd0, 4'd0, 1);
        check_val("fetch_upc", 32'(upc), 1);

        // Dispatch: valid then invalid
        go(5'd7, 4'd0, 1);
        check_val("disp7_upc", 32'(upc), 2);
        go(5'd0, 4'd0, 1);
        go(5'd31, 4'd0, 1);
        check_val("inval_upc", 32'(upc), 0);
        check_val("inval_ill", 32'(illegal_op), 1);
        go(5'd0, 4'd0, 1);
        check_val("ill_pulse", 32'(illegal_op), 0);

        // Branches
        go(5'd1, 4'b0010, 2);
        check_val("br_taken", 32'(upc), 20);
        go(5'd0, 4'd0, 1);
        go(5'd1, 4'b0000, 2);
        check_val("br_fall", 32'(upc), 11);
        go(5'd0, 4'd0, 1);
        go(5'd8, 4'b0000, 2);
        check_val("br_inv", 32'(upc), 20);
        go(5'd0, 4'd0, 1);
        go(5'd8, 4'b0010, 2);
        check_val("br_inv_fall", 32'(upc), 13);
        go(5'd0, 4'd0, 1);
        go(5'd11, 4'b0000, 2);
        check_val("br_wrap", 32'(upc), 0);
        go(5'd0, 4'd0, 1);
        go(5'd12, 4'b1000, 2);
        check_val("br_sel3", 32'(upc), 1);
        go(5'd13, 4'b0000, 2);
        check_val("br_sel2_inv", 32'(upc), 1);

        // Call / return
        go(5'd2, 4'd0, 2);
        check_val("call_upc", 32'(upc), 25);
        go(5'd0, 4'd0, 2);
        check_val("ret_upc", 32'(upc), 15);
        check_val("ret_err", 32'(stack_err), 0);
        go(5'd0, 4'd0, 1);

        // Nested calls to full depth plus an overflowing call
        go(5'd3, 4'd0, 1);
        for (int i = 0; i < 10; i++) begin
            go(5'd0, 4'd0, 1);
            check_val($sformatf("nest_upc%0d", i), 32'(upc), nest_exp[i]);
        end
        check_val("overflow_err", 32'(stack_err), 1);

        // Reset mid-routine at depth 2
        go(5'd3, 4'd0, 1);
        go(5'd0, 4'd0, 7);
        check_val("mid_upc9", 32'(upc), 9);
        rst_cycles(3);
        check_val("mid_rst_sig", 32'(signals), 0);
        check_val("mid_rst_err", 32'(stack_err), 0);
        go(5'd0, 4'd0, 2);
        go(5'd4, 4'd0, 2);
        check_val("underflow_upc", 32'(upc), 0);
        check_val("underflow_err", 32'(stack_err), 1);

        // Reserved seq_ops
        for (int i = 0; i < 3; i++) begin
            rst_cycles(1);
            go(5'd0, 4'd0, 2);
            go(5'(rsv_ops[i]), 4'd0, 2);
            check_val($sformatf("rsv_upc%0d", i), 32'(upc), 0);
            check_val($sformatf("rsv_err%0d", i), 32'(stack_err), 1);
        end

        // Stall on a dispatch word with a changing opcode
        rst_cycles(1);
        go(5'd0, 4'd0, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 5'(stall_ops[i]), 4'd0);
            check_val($sformatf("stall_upc%0d", i), 32'(upc), 1);
            check_val($sformatf("stall_ill%0d", i), 32'(illegal_op), 0);
        end
        go(5'd7, 4'd0, 1);
        check_val("stall_rel_upc", 32'(upc), 2);
        go(5'd0, 4'd0, 1);
        go(5'd31, 4'd0, 1);
        cyc(1'b0, 1'b1, 5'd31, 4'd0);
        check_val("stall_kills_ill", 32'(illegal_op), 0);
        go(5'd0, 4'd0, 1);
        go(5'd2, 4'd0, 1);
        cyc(1'b0, 1'b1, 5'd0, 4'd0);
        cyc(1'b0, 1'b1, 5'd0, 4'd0);
        check_val("stall_call_upc", 32'(upc), 14);
        go(5'd0, 4'd0, 3);
        check_val("stall_call_ret", 32'(upc), 15);
        check_val("stall_call_err", 32'(stack_err), 0);
        cyc(1'b1, 1'b1, 5'd0, 4'd0);
        check_val("rst_over_stall_upc", 32'(upc), 0);
        check_val("rst_over_stall_sig", 32'(signals), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised, resettable microprogrammed control sequencer; next generation of the CPU control unit.
- Holds the microprogram store and a separate opcode dispatch table, both loaded from memory files.
- Adds a synchronous reset, a pipeline stall, flag-conditional branches and a micro-subroutine call/return stack.
- Sits between the instruction register (opcode = ir[15:11]) plus ALU flags and the datapath control signals.

Parameters:
ADDR_W, 5, micro-address width; store depth is 2**ADDR_W
SIG_W, 24, datapath control signal bundle width
OPCODE_W, 5, opcode width; dispatch table depth is 2**OPCODE_W
FLAGS_W, 4, condition flag count; CSEL_W = $clog2(FLAGS_W)
STACK_DEPTH, 4, call stack entries (>=1)
FETCH_ADDR, 0, fetch micro-routine address; also the target for illegal opcodes and errors
MICRO_FILE, "microprogram_clean.mem", binary store image
DISPATCH_FILE, "dispatch.mem", binary dispatch image; each entry is {valid, addr[ADDR_W-1:0]}

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hold all sequencer state this cycle
opcode  in  OPCODE_W  instruction opcode
flags  in  FLAGS_W  datapath condition flags
signals  out  SIG_W  control signals of the current microword
upc  out  ADDR_W  address of the current microword
illegal_op  out  1  one-cycle pulse on dispatch to an invalid entry
stack_err  out  1  sticky stack overflow/underflow/reserved-op flag

Behaviour:
- Microword layout, MSB to LSB: {next_addr[ADDR_W], signals[SIG_W], cond_inv, cond_sel[CSEL_W], seq_op[3]}.
- The registered current word drives signals combinationally. Each cycle: current <= store[chosen], upc <= chosen.
- seq_op selects chosen:
  - 0 NEXT: chosen = next_addr.
  - 1 DISPATCH: chosen = dispatch[opcode].addr if valid; otherwise chosen = FETCH_ADDR and illegal_op = 1 in the following cycle.
  - 2 BRANCH: take = flags[cond_sel] ^ cond_inv, sampled in the same cycle. chosen = take ? next_addr : upc+1.
  - 3 CALL: push upc+1, then chosen = next_addr.
  - 4 RET: chosen = popped address.
  - 5-7 reserved: chosen = FETCH_ADDR and stack_err is set.
- upc+1 wraps modulo 2**ADDR_W.
- Stack:
  - LIFO with pointer sp in 0..STACK_DEPTH.
  - CALL when sp == STACK_DEPTH: no push, jump still taken, stack_err set.
  - RET when sp == 0: chosen = FETCH_ADDR, stack_err set.
- Reset (rst = 1, overrides stall):
  - current <= 0, so signals = 0 and the op is NEXT to address 0.
  - upc <= 0, sp <= 0, illegal_op <= 0, stack_err <= 0.
  - The first cycle after rst drops fetches store[0], i.e. 1-cycle reset latency to valid signals.
- Reset mid-routine abandons the routine and clears the stack. No other way clears stack_err.
- stall = 1 (and rst = 0):
  - current, upc, sp, stack contents and stack_err hold; signals are unchanged.
  - illegal_op is forced to 0 and the decision is re-evaluated after release.
  - opcode/flags are re-sampled on the release cycle.
- Latency: one microword per unstalled cycle for all seq_ops, with no bubbles.
- No simulation-only prints in the decision path; the $display of the next address is kept for debug only.

Decomposition:
- Shared include (constants.v): seq_op encodings (SEQ_NEXT..SEQ_RET), field offset macros derived from parameters, and the default FETCH_ADDR.
- One natural sub-module: micro_call_stack (push, pop, full, empty, top; parametrised by ADDR_W and STACK_DEPTH).
- Store and dispatch ROMs stay inline as initial $readmemb arrays.

Test Plan:
- Reset: hold rst 3 cycles mid-routine at upc = 9 with sp = 2 -> signals = 0 and upc = 0 during reset; the cycle after release gives upc = 0 with store[0] signals; sp = 0.
- Dispatch: opcode 5'b00111 with dispatch[7] = {1, 2} -> upc = 2 one cycle after the DISPATCH word. Invalid entry for 5'b11111 -> upc = FETCH_ADDR and illegal_op high exactly 1 cycle.
- Branch: word at 10 = BRANCH cond_sel = 1, cond_inv = 0, next = 20. flags = 4'b0010 -> upc 20; flags = 0 -> upc 11; cond_inv = 1 with flags = 0 -> upc 20.
- Call/return: CALL at 14 -> 25, RET at 26 -> upc 15. Nested calls to depth 4 return in LIFO order; a fifth CALL still jumps and sets stack_err.
- Underflow/reserved: RET with empty stack -> upc = FETCH_ADDR and stack_err = 1; seq_op 6 -> same.
- Stall: assert stall for 4 cycles on a DISPATCH word while opcode changes -> upc/signals frozen, illegal_op = 0; after release, dispatch uses the opcode present on the release cycle. stall plus rst together -> reset wins.
